// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the
// memory-access pipeline stage.
package mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] read_data;
    logic [REG_AW_DEF-1:0] rd_addr;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack bus between the
// memory stage (master) and the data memory (slave).
interface mem_stage_if #(
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load enable,
// valid-only kill and synchronous active-low clear.
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_n_i,
  input  logic    i_en,
  input  logic    i_kill,
  input  mem_wb_t i_d,
  output mem_wb_t o_q
);

  mem_wb_t r_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end else if (i_kill) begin
      r_q.valid <= 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store issue over req/ack, branch resolve,
// MEM/WB register. Optional ack timeout: MEM_TIMEOUT_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] sum_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic              Branch_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  output logic              stall_o,
  output logic              PCSrc_o,
  output logic [DATA_W-1:0] branch_target_o,
  mem_stage_if.master       dmem,
  output logic              wb_valid_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              err_o
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT must be >= 2");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  mem_wb_t           w_wb_d;
  mem_wb_t           w_wb_q;
  logic              w_memop;
  logic              w_cap;
  logic              w_done;
  logic              w_tmo;
  logic              w_wb_en;
  logic              w_kill;
  logic              w_stall;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  assign w_memop = valid_i & (MemRead_i | MemWrite_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_cap       = 1'b0;
    w_done      = 1'b0;
    w_wb_en     = 1'b0;
    w_kill      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_memop) begin
          w_stall     = 1'b1;
          w_cap       = 1'b1;
          w_kill      = 1'b1;
          w_state_nxt = ACCESS;
        end else begin
          w_wb_en = 1'b1;
        end
      end
      ACCESS: begin
        // a timeout retires the op like an ack
        if (dmem.ack | w_tmo) begin
          w_done      = 1'b1;
          w_wb_en     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_stall = 1'b1;
          w_kill  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wb_d            = '0;
    w_wb_d.valid      = (r_state == ACCESS) | valid_i;
    w_wb_d.reg_write  = RegWrite_i & ~w_tmo;
    w_wb_d.mem_to_reg = MemtoReg_i;
    w_wb_d.alu_result = ALUResult_i;
    w_wb_d.rd_addr    = RDaddr_i;
    if ((r_state == ACCESS) && dmem.ack && !r_we) begin
      w_wb_d.read_data = dmem.rdata;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_en    (w_wb_en),
    .i_kill  (w_kill),
    .i_d     (w_wb_d),
    .o_q     (w_wb_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_cap) begin
      r_req   <= 1'b1;
      r_we    <= MemWrite_i;
      r_addr  <= {ALUResult_i[DATA_W-1:2], 2'b00};
      r_wdata <= RTdata_i;
    end else if (w_done) begin
      r_req <= 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] r_cnt;
  logic            r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_cap) begin
      r_cnt <= '0;
    end else if ((r_state == ACCESS) && !dmem.ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tmo = (r_state == ACCESS) & ~dmem.ack
               & (r_cnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_err <= 1'b0;
    end else if (w_tmo) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_tmo = 1'b0;
  assign err_o = 1'b0;
`endif

  assign stall_o         = w_stall;
  assign PCSrc_o         = valid_i & Branch_i & zero_i;
  assign branch_target_o = sum_i;

  assign dmem.req   = r_req;
  assign dmem.we    = r_we;
  assign dmem.addr  = r_addr;
  assign dmem.wdata = r_wdata;

  assign wb_valid_o  = w_wb_q.valid;
  assign RegWrite_o  = w_wb_q.reg_write;
  assign MemtoReg_o  = w_wb_q.mem_to_reg;
  assign ALUResult_o = w_wb_q.alu_result;
  assign ReadData_o  = w_wb_q.read_data;
  assign RDaddr_o    = w_wb_q.rd_addr;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage
// with a behavioural data-memory responder.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] sum_i;
  logic [31:0] ALUResult_i;
  logic        zero_i;
  logic [31:0] RTdata_i;
  logic [4:0]  RDaddr_i;
  logic        Branch_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic        stall_o;
  logic        PCSrc_o;
  logic [31:0] branch_target_o;
  logic        wb_valid_o;
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic [31:0] ALUResult_o;
  logic [31:0] ReadData_o;
  logic [4:0]  RDaddr_o;
  logic        err_o;

  mem_stage_if #(.DATA_W(32)) bus ();

  mem_stage #(
    .DATA_W  (32),
    .REG_AW  (5),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .valid_i         (valid_i),
    .sum_i           (sum_i),
    .ALUResult_i     (ALUResult_i),
    .zero_i          (zero_i),
    .RTdata_i        (RTdata_i),
    .RDaddr_i        (RDaddr_i),
    .Branch_i        (Branch_i),
    .MemRead_i       (MemRead_i),
    .MemWrite_i      (MemWrite_i),
    .RegWrite_i      (RegWrite_i),
    .MemtoReg_i      (MemtoReg_i),
    .stall_o         (stall_o),
    .PCSrc_o         (PCSrc_o),
    .branch_target_o (branch_target_o),
    .dmem            (bus),
    .wb_valid_o      (wb_valid_o),
    .RegWrite_o      (RegWrite_o),
    .MemtoReg_o      (MemtoReg_o),
    .ALUResult_o     (ALUResult_o),
    .ReadData_o      (ReadData_o),
    .RDaddr_o        (RDaddr_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] mem_arr[logic [31:0]];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          force_d = -1;
  int          last_d  = 0;
  bit          hold    = 1'b0;
  bit          inject_ack = 1'b0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // data memory: random (or forced) ack delay per request
  initial begin
    bit busy = 1'b0;
    int cnt  = 0;
    int cur  = 0;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    forever begin
      @(negedge clk);
      bus.ack   = 1'b0;
      bus.rdata = $urandom;
      if (!bus.req) busy = 1'b0;
      if (inject_ack) begin
        bus.ack    = 1'b1;
        inject_ack = 1'b0;
      end else if (bus.req) begin
        if (!busy) begin
          busy = 1'b1;
          cur  = (force_d >= 0) ? force_d : $urandom_range(0, 3);
          cnt  = cur;
          chk("dmem_addr", bus.addr, {ALUResult_i[31:2], 2'b00});
          chk("dmem_we", bus.we, MemWrite_i);
          if (MemWrite_i) chk("dmem_wdata", bus.wdata, RTdata_i);
        end
        if (!hold) begin
          if (cnt == 0) begin
            bus.ack = 1'b1;
            busy    = 1'b0;
            last_d  = cur;
            if (bus.we) mem_arr[bus.addr] = bus.wdata;
            else if (mem_arr.exists(bus.addr))
              bus.rdata = mem_arr[bus.addr];
            else bus.rdata = init_val(bus.addr);
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // monitor: every retired instruction pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid_o) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wb_unexpected: wb_valid_o=1 expected 0");
        end else begin
          e = sb.pop_front();
          chk("wb_regwrite", RegWrite_o, e.rw);
          chk("wb_memtoreg", MemtoReg_o, e.m2r);
          chk("wb_alu", ALUResult_o, e.alu);
          chk("wb_rd", RDaddr_o, e.rd);
          chk("wb_rdata", ReadData_o, e.rdata);
        end
      end
    end
  end

  task automatic drive(input logic v, br, mr, mw, rw, m2r, z,
                       input logic [31:0] alu, sum, rt,
                       input logic [4:0] rd);
    valid_i     = v;
    Branch_i    = br;
    MemRead_i   = mr;
    MemWrite_i  = mw;
    RegWrite_i  = rw;
    MemtoReg_i  = m2r;
    zero_i      = z;
    ALUResult_i = alu;
    sum_i       = sum;
    RTdata_i    = rt;
    RDaddr_i    = rd;
  endtask

  task automatic issue(input logic v, br, mr, mw, rw, m2r, z,
                       input logic [31:0] alu, sum, rt,
                       input logic [4:0] rd, output int cyc);
    logic        memop;
    logic [31:0] wa;
    bit          ok;
    exp_t        e;
    @(negedge clk);
    drive(v, br, mr, mw, rw, m2r, z, alu, sum, rt, rd);
    memop = v & (mr | mw);
    wa    = {alu[31:2], 2'b00};
    cyc   = 0;
    ok    = 1'b1;
    forever begin
      #4;
      cyc++;
      chk("pcsrc", PCSrc_o, v & br & z);
      chk("br_target", branch_target_o, sum);
      if (!stall_o) break;
      if (cyc >= 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL stall_bound: stall_o=1 after %0d cycles", cyc);
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      chk("stall_cycles", cyc, memop ? 2 + last_d : 1);
      if (v) begin
        e.rw    = rw;
        e.m2r   = m2r;
        e.alu   = alu;
        e.rd    = rd;
        e.rdata = (memop && !mw) ? ref_rd(wa) : 32'h0;
        sb.push_back(e);
      end
      if (memop && mw) ref_mem[wa] = rt;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wb_valid"}, wb_valid_o, 0);
    chk({tag, "_regwrite"}, RegWrite_o, 0);
    chk({tag, "_memtoreg"}, MemtoReg_o, 0);
    chk({tag, "_alu"}, ALUResult_o, 0);
    chk({tag, "_rdata"}, ReadData_o, 0);
    chk({tag, "_rd"}, RDaddr_o, 0);
    chk({tag, "_req"}, bus.req, 0);
    chk({tag, "_we"}, bus.we, 0);
    chk({tag, "_addr"}, bus.addr, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic        v, br, mr, mw;
    logic [31:0] alu;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_reset("reset");

    issue(1, 0, 0, 0, 1, 0, 0, 32'h10, 0, 0, 5'd3, cyc);
    chk("alu_latency", cyc, 1);

    ref_mem[32'h20] = 32'hDEAD_BEEF;
    mem_arr[32'h20] = 32'hDEAD_BEEF;
    force_d = 2;
    issue(1, 0, 1, 0, 1, 1, 0, 32'h23, 0, 0, 5'd7, cyc);
    chk("load_stall", cyc, 4);

    force_d = 0;
    issue(1, 0, 0, 1, 0, 0, 0, 32'h40, 0, 32'h55, 5'd0, cyc);
    chk("store_stall", cyc, 2);
    force_d = -1;
    issue(1, 0, 1, 1, 1, 0, 0, 32'h41, 0, 32'hA5, 5'd9, cyc);
    issue(1, 0, 1, 0, 1, 1, 0, 32'h42, 0, 0, 5'd4, cyc);

    issue(1, 1, 0, 0, 0, 0, 1, 32'h0, 32'h100, 0, 5'd0, cyc);
    issue(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h100, 0, 5'd0, cyc);
    issue(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h200, 0, 5'd0, cyc);

    for (int i = 0; i < 300; i++) begin
      v   = ($urandom_range(0, 7) != 0);
      br  = $urandom_range(0, 1);
      mr  = ($urandom_range(0, 2) == 0);
      mw  = ($urandom_range(0, 3) == 0);
      alu = (mr | mw) ? 32'($urandom_range(0, 63)) : $urandom;
      issue(v, br, mr, mw, 1'($urandom), 1'($urandom),
            1'($urandom), alu, $urandom, $urandom,
            5'($urandom), cyc);
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // reset while a load is waiting, then a stray ack
    hold = 1'b1;
    drive(1, 0, 1, 0, 1, 1, 0, 32'h80, 0, 0, 5'd6);
    repeat (3) @(negedge clk);
    #4;
    chk("acc_req", bus.req, 1);
    chk("acc_stall", stall_o, 1);
    chk("acc_wb_bubble", wb_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_reset("rst_mid");
    rst_n      = 1'b1;
    inject_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("late_ack_wb", wb_valid_o, 0);
    chk("late_ack_req", bus.req, 0);
    chk("late_ack_rdata", ReadData_o, 0);
    chk("late_ack_stall", stall_o, 0);
    hold = 1'b0;

`ifdef MEM_TIMEOUT_EN
    begin
      exp_t e;
      int   nreq;
      hold  = 1'b1;
      e.rw  = 1'b0;
      e.m2r = 1'b1;
      e.alu = 32'h84;
      e.rd  = 5'd2;
      e.rdata = 32'h0;
      sb.push_back(e);
      @(negedge clk);
      drive(1, 0, 1, 0, 1, 1, 0, 32'h84, 0, 0, 5'd2);
      nreq = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        #1;
        if (bus.req) nreq++;
        if (!stall_o) break;
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("tmo_req_cycles", nreq, TMO);
      @(negedge clk);
      chk("tmo_req_low", bus.req, 0);
      chk("tmo_err", err_o, 1);
      hold = 1'b0;
      repeat (2) @(negedge clk);
      chk("tmo_err_sticky", err_o, 1);
      chk("tmo_sb_drained", sb.size(), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
